// File: rtl/freq_bar_reader.sv
`timescale 1ns/1ps
// freq_bar_reader: scans the lower half of the FFT frequency memory once per
// frame, reduces each group of BINS_PER_COL bins to a max-height bar per
// column, and keeps a slowly decaying peak-hold per column.
// Ports:
//   ckFreq, aresetn             clock / async active-low reset
//   flgFrameStart               one-cycle pulse starting a scan (IDLE only)
//   addrFreqRd / byteFreqRd     frequency memory read port (1-cycle latency)
//   colIdx                      column requested by the pixel path
//   byteBarHeight/PeakHeight    registered bar / peak of colIdx
//   flgBusy, flgFrameDone       scan in progress / one-cycle completion pulse
module freq_bar_reader #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned NUM_COLS     = 64,
  parameter int unsigned BINS_PER_COL = 8,
  parameter int unsigned DECAY_DIV    = 4
) (
  input  logic                        ckFreq,
  input  logic                        aresetn,
  input  logic                        flgFrameStart,
  output logic [ADDR_W-1:0]           addrFreqRd,
  input  logic [7:0]                  byteFreqRd,
  input  logic [$clog2(NUM_COLS)-1:0] colIdx,
  output logic [7:0]                  byteBarHeight,
  output logic [7:0]                  bytePeakHeight,
  output logic                        flgBusy,
  output logic                        flgFrameDone
);

  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned BIN_W     = $clog2(BINS_PER_COL);
  localparam int unsigned SCAN_W    = COL_W + BIN_W;
  localparam int unsigned SCAN_LAST = NUM_COLS * BINS_PER_COL - 1;
  localparam int unsigned DEC_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [DEC_W-1:0]    r_dec;
  logic [DEC_W-1:0]    w_dec_nxt;

  logic                r_vld;
  logic [SCAN_W-1:0]   r_addr_d;
  logic [7:0]          r_max;
  logic [7:0]          r_bar  [NUM_COLS];
  logic [7:0]          r_peak [NUM_COLS];

  logic [BIN_W-1:0]    w_bin;
  logic [COL_W-1:0]    w_col;
  logic                w_last_bin;
  logic [7:0]          w_max;
  logic [7:0]          w_peak_old;
  logic [7:0]          w_peak_new;
  logic                w_tick;

  // State register
  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (flgFrameStart) w_state_nxt = S_SCAN;
      S_SCAN:  if (addrFreqRd == ADDR_W'(SCAN_LAST)) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values; actions take effect on the edge leaving each state
  always_comb begin
    w_addr_nxt = addrFreqRd;
    w_busy_nxt = flgBusy;
    w_done_nxt = 1'b0;
    w_dec_nxt  = r_dec;
    case (r_state)
      S_IDLE: if (flgFrameStart) begin
        w_addr_nxt = '0;
        w_busy_nxt = 1'b1;
      end
      S_SCAN: if (addrFreqRd != ADDR_W'(SCAN_LAST)) w_addr_nxt = addrFreqRd + ADDR_W'(1);
      S_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        w_dec_nxt  = (r_dec == DEC_W'(DECAY_DIV - 1)) ? '0 : r_dec + DEC_W'(1);
      end
      default: ;
    endcase
  end

  // Registered control outputs and decay frame counter
  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) begin
      addrFreqRd   <= '0;
      flgBusy      <= 1'b0;
      flgFrameDone <= 1'b0;
      r_dec        <= '0;
    end else begin
      addrFreqRd   <= w_addr_nxt;
      flgBusy      <= w_busy_nxt;
      flgFrameDone <= w_done_nxt;
      r_dec        <= w_dec_nxt;
    end
  end

  // Delayed copy of the issued address: tags the datum arriving this cycle
  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) begin
      r_vld    <= 1'b0;
      r_addr_d <= '0;
      r_max    <= '0;
    end else begin
      r_vld    <= (r_state == S_SCAN);
      r_addr_d <= addrFreqRd[SCAN_W-1:0];
      if (r_vld) r_max <= w_max;
    end
  end

  // Column reduction and peak-hold update
  always_comb begin
    w_bin      = r_addr_d[BIN_W-1:0];
    w_col      = r_addr_d[SCAN_W-1:BIN_W];
    w_last_bin = (w_bin == BIN_W'(BINS_PER_COL - 1));
    // first bin of a column restarts the max instead of carrying it over
    w_max      = ((w_bin == '0) || (byteFreqRd > r_max)) ? byteFreqRd : r_max;
    w_tick     = (r_dec == '0);
    w_peak_old = r_peak[w_col];
    if (w_max >= w_peak_old)             w_peak_new = w_max;
    else if (w_tick && w_peak_old != '0) w_peak_new = w_peak_old - 8'd1;
    else                                 w_peak_new = w_peak_old;
  end

  // Bar / peak storage and pixel-path read registers
  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_COLS); i++) begin
        r_bar[i]  <= '0;
        r_peak[i] <= '0;
      end
      byteBarHeight  <= '0;
      bytePeakHeight <= '0;
    end else begin
      if (r_vld && w_last_bin) begin
        r_bar[w_col]  <= w_max;
        r_peak[w_col] <= w_peak_new;
      end
      byteBarHeight  <= r_bar[colIdx];
      bytePeakHeight <= r_peak[colIdx];
    end
  end

endmodule

// File: tb/tb_freq_bar_reader.sv
`timescale 1ns/1ps
// Directed bench for freq_bar_reader with a synchronous frequency-memory model.
module tb_freq_bar_reader;

  localparam int SCAN_LAT = 514;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] addr;
  logic [7:0] rdata;
  logic [5:0] col_idx;
  logic [7:0] bar_h;
  logic [7:0] peak_h;
  logic       busy;
  logic       done;

  logic [7:0] mem [1024];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int col;
    int exp_bar;
    int exp_peak;
  } col_vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[addr];

  freq_bar_reader dut (
    .ckFreq         (clk),
    .aresetn        (rst_n),
    .flgFrameStart  (start),
    .addrFreqRd     (addr),
    .byteFreqRd     (rdata),
    .colIdx         (col_idx),
    .byteBarHeight  (bar_h),
    .bytePeakHeight (peak_h),
    .flgBusy        (busy),
    .flgFrameDone   (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    start   = 1'b0;
    col_idx = 6'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_col(input int c, output int b, output int p);
    @(negedge clk);
    col_idx = 6'(c);
    @(negedge clk);
    b = int'(bar_h);
    p = int'(peak_h);
  endtask

  // Pulse start, follow the scan cycle by cycle, then watch 20 idle cycles.
  task automatic run_scan(input int glitch_at, output int lat, output int seq_bad,
                          output int dones);
    int exp_a;
    lat = -1; seq_bad = 0; dones = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 700 && lat < 0; k++) begin
      start = (k == glitch_at);
      exp_a = (k <= 511) ? k : 511;
      if (int'(addr) != exp_a) seq_bad++;
      if (done) begin
        lat = k;
        dones++;
        if (busy) seq_bad++;
      end else begin
        if (!busy) seq_bad++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) seq_bad++;
    end
  endtask

  task automatic quiet_scan();
    int l, s, d;
    run_scan(-1, l, s, d);
  endtask

  initial begin
    col_vec_t ramp_vec [6];
    int lat, seq_bad, dones, b, p, bad;

    ramp_vec[0] = '{0, 7, 7};
    ramp_vec[1] = '{1, 15, 15};
    ramp_vec[2] = '{17, 143, 143};
    ramp_vec[3] = '{31, 255, 255};
    ramp_vec[4] = '{32, 7, 7};
    ramp_vec[5] = '{63, 255, 255};

    rst_n = 1'b0; start = 1'b0; col_idx = 6'd0;
    fill_zero();
    do_reset();

    // Reset state
    check("rst_addr", int'(addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    read_col(63, b, p);
    check("rst_bar63", b, 0);
    check("rst_peak63", p, 0);

    // Ramp memory: bar[c] = (8c+7) mod 256, peak equals bar
    fill_ramp();
    run_scan(-1, lat, seq_bad, dones);
    check("ramp_latency", lat, SCAN_LAT);
    check("ramp_addr_seq", seq_bad, 0);
    check("ramp_done_pulses", dones, 1);
    foreach (ramp_vec[i]) begin
      read_col(ramp_vec[i].col, b, p);
      check($sformatf("ramp_bar[%0d]", ramp_vec[i].col), b, ramp_vec[i].exp_bar);
      check($sformatf("ramp_peak[%0d]", ramp_vec[i].col), p, ramp_vec[i].exp_peak);
    end
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      read_col(c, b, p);
      if (b != ((8 * c + 7) % 256) || p != b) bad++;
    end
    check("ramp_all_cols", bad, 0);

    // Column max reduction with a fresh running max per column
    do_reset();
    fill_zero();
    mem[8] = 8'd3;  mem[9] = 8'd200; mem[10] = 8'd9; mem[11] = 8'd0;
    mem[12] = 8'd255; mem[13] = 8'd1; mem[14] = 8'd1; mem[15] = 8'd1;
    quiet_scan();
    read_col(1, b, p); check("max_bar1", b, 255);
    read_col(0, b, p); check("max_bar0", b, 0);
    read_col(2, b, p); check("max_bar2", b, 0);

    // Peak decay: one decrement every 4 scans
    do_reset();
    fill_zero();
    mem[42] = 8'd100;
    quiet_scan();
    read_col(5, b, p); check("decay_s1_bar", b, 100); check("decay_s1_peak", p, 100);
    fill_zero();
    for (int s = 2; s <= 9; s++) begin
      quiet_scan();
      read_col(5, b, p);
      if (s == 2) begin check("decay_s2_bar", b, 0); check("decay_s2_peak", p, 100); end
      if (s == 4) check("decay_s4_peak", p, 100);
      if (s == 5) check("decay_s5_peak", p, 99);
      if (s == 8) check("decay_s8_peak", p, 99);
      if (s == 9) begin check("decay_s9_peak", p, 98); check("decay_s9_bar", b, 0); end
    end

    // Peak saturates at zero
    do_reset();
    fill_zero();
    mem[3] = 8'd1;
    quiet_scan();
    read_col(0, b, p); check("sat_s1_peak", p, 1);
    fill_zero();
    for (int s = 2; s <= 9; s++) begin
      quiet_scan();
      read_col(0, b, p);
      if (s == 4) check("sat_s4_peak", p, 1);
      if (s == 5) check("sat_s5_peak", p, 0);
      if (s == 9) check("sat_s9_peak", p, 0);
    end

    // Start pulse during a scan is ignored
    fill_ramp();
    run_scan(100, lat, seq_bad, dones);
    check("glitch_latency", lat, SCAN_LAT);
    check("glitch_addr_seq", seq_bad, 0);
    check("glitch_done_pulses", dones, 1);

    // Start held high: back-to-back scans, one idle cycle between
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    lat = -1;
    for (int k = 0; k < 700 && lat < 0; k++) begin
      if (done) lat = k; else @(negedge clk);
    end
    check("held_latency1", lat, SCAN_LAT);
    check("held_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_addr", int'(addr), 0);
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 700 && lat < 0; k++) begin
      if (done) lat = k; else @(negedge clk);
    end
    check("held_latency2", lat, SCAN_LAT);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check("held_stops", bad, 0);

    // Asynchronous reset mid-scan
    read_col(1, b, p);
    check("prereset_bar1", b, 15);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", int'(addr), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_bar_out", int'(bar_h), 0);
    check("mid_rst_peak_out", int'(peak_h), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      read_col(c, b, p);
      if (b != 0 || p != 0) bad++;
    end
    check("mid_rst_arrays", bad, 0);
    run_scan(-1, lat, seq_bad, dones);
    check("post_rst_latency", lat, SCAN_LAT);
    check("post_rst_addr_seq", seq_bad, 0);
    read_col(32, b, p);
    check("post_rst_bar32", b, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_bar_reader.md
Name: freq_bar_reader

Overview:
- Reader side of the FFT frequency-sample memory; consumes what the FFT block writes (10-bit address, 8-bit power byte per bin).
- On each frame-start pulse from the display timing, scans the lower half-spectrum, reduces groups of bins to one bar height per display column, and maintains a decaying peak-hold per column.
- Results sit in register arrays so the VGA pixel path can index any column at any time during active video.

Parameters:
- ADDR_W, 10, frequency memory address width
- NUM_COLS, 64, number of display bars (power of 2)
- BINS_PER_COL, 8, bins reduced per bar (power of 2); bins 0..NUM_COLS*BINS_PER_COL-1 are scanned
- DECAY_DIV, 4, peak-hold decrements once every DECAY_DIV completed scans

Ports:
- ckFreq  in  1  frequency-domain clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- flgFrameStart  in  1  one-cycle pulse that starts a scan
- addrFreqRd  out  ADDR_W  read address to the frequency memory
- byteFreqRd  in  8  read data; valid exactly 1 cycle after the address
- colIdx  in  log2(NUM_COLS)  column requested by the pixel path
- byteBarHeight  out  8  bar height of colIdx, registered
- bytePeakHeight  out  8  peak-hold of colIdx, registered
- flgBusy  out  1  high while scanning
- flgFrameDone  out  1  one-cycle pulse when all columns are updated

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State IDLE.
  - addrFreqRd, byteBarHeight, bytePeakHeight, flgBusy, flgFrameDone = 0.
  - All bar and peak registers = 0; decay frame counter = 0.
- States: IDLE, SCAN, DRAIN, DONE.
  - IDLE: flgFrameStart=1 -> SCAN; addrFreqRd <= 0; flgBusy <= 1.
  - SCAN: addrFreqRd increments by 1 each cycle. When addrFreqRd = NUM_COLS*BINS_PER_COL-1 is issued -> DRAIN.
  - DRAIN: one cycle to capture the final read datum -> DONE.
  - DONE: flgFrameDone=1 for exactly one cycle; flgBusy <= 0; decay counter advances, wrapping at DECAY_DIV-1 -> IDLE.
- Read pipeline: address A issued in cycle t; byteFreqRd for A is sampled in cycle t+1.
  - Track the in-flight address with a 1-cycle delayed copy; the column index is addr[high bits] and the bin index is addr[low log2(BINS_PER_COL) bits].
- Reduction (unsigned 8-bit max):
  - Running max resets to the first bin of each column (bin index 0), not carried over from the previous column.
  - On the cycle the last bin of column c (bin index BINS_PER_COL-1) is sampled, the max is written to bar[c].
- Peak update, in the same cycle as the bar[c] write, with new height h:
  - If h >= peak[c]: peak[c] <= h.
  - Else if the decay tick is active (decay counter = 0 during this scan): peak[c] <= peak[c]-1, saturating at 0.
  - Else peak[c] holds.
- Scan length: NUM_COLS*BINS_PER_COL address cycles + DRAIN + DONE. Defaults: flgFrameDone 514 cycles after the cycle flgFrameStart is sampled.
- Pixel path: byteBarHeight <= bar[colIdx], bytePeakHeight <= peak[colIdx], 1-cycle latency, every cycle, in every state.
  - A column updated mid-scan is visible from the next cycle; other columns keep their previous-scan values.
- Boundaries:
  - flgFrameStart in SCAN, DRAIN or DONE: ignored, no restart, no queueing.
  - flgFrameStart held high: one scan per IDLE entry; scans run back-to-back, one idle cycle between them.
  - addrFreqRd never exceeds NUM_COLS*BINS_PER_COL-1; it holds its last value in IDLE.
  - Reset mid-scan: immediate return to the reset values above; no partial column write.

Test Plan:
- Reset then pulse flgFrameStart with memory[i]=i[7:0] -> addrFreqRd 0..511, flgFrameDone at cycle 514; bar[c]=(8c+7) mod 256 (bar[31]=255, bar[32]=7); peak[c] equals bar[c].
- Column max reduction: memory bins 8..15 = {3,200,9,0,255,1,1,1}, all others 0 -> bar[1]=255, bar[0]=0, bar[2]=0.
- Peak decay, DECAY_DIV=4: scan 1 with bar[5]=100, then memory all zero -> peak[5]=100 after scan 1, 99 after scan 5, 98 after scan 9; bar[5]=0 from scan 2 on.
- Peak saturation: peak[0]=1, zero data across 8 scans -> peak[0] reaches 0 and stays 0, never 255.
- flgFrameStart pulsed again at cycle 100 of a scan -> ignored; exactly one flgFrameDone; addrFreqRd sequence uninterrupted.
- aresetn low at cycle 200 of a scan -> outputs 0 asynchronously, all bars/peaks 0, flgBusy=0; a new flgFrameStart then completes a normal 514-cycle scan.
